// File: rtl/imem_fetch.sv
// Instruction fetch stage: owns the PC, issues reads to the 2048x32 BSRAM and
// hands words to decode through a 1-entry skid buffer with branch redirects.
module imem_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          IMEM_AW  = 11
) (
   input  logic               clk,
   input  logic               reset,
   output logic [IMEM_AW-1:0] imem_ad,
   output logic               imem_ce,
   output logic               imem_oce,
   input  logic [31:0]        imem_dout,
   input  logic               redirect_valid,
   input  logic [31:0]        redirect_pc,
   output logic               if_valid,
   input  logic               if_ready,
   output logic [31:0]        if_pc,
   output logic [31:0]        if_instr,
   output logic               if_fault
);

   logic [31:0] pc;
   logic        rsp_valid;
   logic [31:0] rsp_pc;
   logic        sb_valid;
   logic [31:0] sb_pc;
   logic [31:0] sb_instr;

   logic        issue;
   logic [31:0] issue_pc;
   logic [31:0] sel_pc;
   logic [31:0] sel_instr;

   // Issue never looks at if_ready: a full skid buffer is the only back-pressure,
   // which keeps the decode stall off the memory address path.
   always_comb begin
      issue     = redirect_valid | ~sb_valid;
      issue_pc  = redirect_valid ? redirect_pc : pc;
      imem_ce   = ~reset & issue;
      imem_ad   = issue_pc[IMEM_AW+1:2];
      imem_oce  = 1'b1;
      sel_pc    = sb_valid ? sb_pc : rsp_pc;
      sel_instr = sb_valid ? sb_instr : imem_dout;
      if_valid  = ~reset & (sb_valid | rsp_valid) & ~redirect_valid;
      if_pc     = reset ? 32'h0 : sel_pc;
      if_instr  = reset ? 32'h0 : sel_instr;
      if_fault  = ~reset & ((|sel_pc[1:0]) | (|sel_pc[31:IMEM_AW+2]));
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order in this block.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc        <= RESET_PC;
         rsp_valid <= 1'b0;
         rsp_pc    <= 32'h0;
         sb_valid  <= 1'b0;
         sb_pc     <= 32'h0;
         sb_instr  <= 32'h0;
      end else begin
         // Redirect flushes the skid entry; an older response is overwritten by the issue below.
         if (redirect_valid) begin
            sb_valid <= 1'b0;
         end else if (sb_valid) begin
            if (if_ready) sb_valid <= 1'b0;
         end else if (rsp_valid && !if_ready) begin
            sb_valid <= 1'b1;
            sb_pc    <= rsp_pc;
            sb_instr <= imem_dout;
         end

         // While the skid buffer is full no read is issued, so imem_dout keeps the pending response.
         if (issue) begin
            rsp_valid <= 1'b1;
            rsp_pc    <= issue_pc;
            pc        <= issue_pc + 32'd4;
         end
      end
   end

endmodule

// File: tb/tb_imem_fetch.sv
// Self-checking bench for imem_fetch: directed vector table, hand-written
// corner sequences, and a randomized run against a stream-level model.
module tb_imem_fetch;

   logic        clk = 1'b0;
   logic        reset;
   logic [10:0] imem_ad;
   logic        imem_ce;
   logic        imem_oce;
   logic [31:0] imem_dout = 32'h0;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic        if_fault;

   int total = 0;
   int bad   = 0;

   logic [31:0] mem [2048];

   imem_fetch #(.RESET_PC(32'h0000_0000), .IMEM_AW(11)) dut (
      .clk            (clk),
      .reset          (reset),
      .imem_ad        (imem_ad),
      .imem_ce        (imem_ce),
      .imem_oce       (imem_oce),
      .imem_dout      (imem_dout),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .if_valid       (if_valid),
      .if_ready       (if_ready),
      .if_pc          (if_pc),
      .if_instr       (if_instr),
      .if_fault       (if_fault)
   );

   always #5 clk = ~clk;

   // Synchronous-read BSRAM: data one cycle after ce, held while ce is low.
   always @(posedge clk) begin
      if (imem_ce) imem_dout <= mem[imem_ad];
   end

   typedef struct {
      logic        ready;
      logic        rv;
      logic [31:0] rpc;
      logic        ce;
      logic [10:0] ad;
      logic        valid;
      logic [31:0] pc;
      logic [31:0] instr;
      logic        fault;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   task automatic add(input logic r, input logic rv, input logic [31:0] rpc, input logic ce,
                      input logic [10:0] ad, input logic v, input logic [31:0] pc,
                      input logic [31:0] instr, input logic f);
      vec_t e;
      e = '{ready: r, rv: rv, rpc: rpc, ce: ce, ad: ad, valid: v, pc: pc, instr: instr, fault: f};
      vecs.push_back(e);
   endtask

   // Reference: word n of memory holds A000_0000+n; the address wraps at 2048 words.
   function automatic logic [31:0] ref_word(input logic [31:0] p);
      return 32'hA000_0000 + ((p >> 2) & 32'h7FF);
   endfunction

   function automatic logic ref_fault(input logic [31:0] p);
      return ((p & 32'h3) != 0) || ((p >> 13) != 0);
   endfunction

   task automatic drive(input logic r, input logic rv, input logic [31:0] rpc);
      if_ready       = r;
      redirect_valid = rv;
      redirect_pc    = rpc;
      @(negedge clk);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_word(input string name, input logic [31:0] pc, input logic f);
      check({name, "_valid"}, {31'd0, if_valid}, 32'd1);
      check({name, "_pc"}, if_pc, pc);
      check({name, "_instr"}, if_instr, ref_word(pc));
      check({name, "_fault"}, {31'd0, if_fault}, {31'd0, f});
   endtask

   logic [31:0] exp_next;
   logic        hold;
   logic [31:0] hold_pc;
   logic [31:0] hold_instr;
   logic        hold_fault;

   initial begin
      for (int i = 0; i < 2048; i++) mem[i] = 32'hA000_0000 + i;

      reset          = 1'b1;
      if_ready       = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;

      // Cycle-by-cycle plan from reset release: stall with skid, redirect over a
      // full skid buffer, then a misaligned redirect.
      add(1'b1, 1'b0, 32'h0,   1'b1, 11'h000, 1'b0, 32'h0,   32'h0,         1'b0);
      add(1'b1, 1'b0, 32'h0,   1'b1, 11'h001, 1'b1, 32'h0,   32'hA000_0000, 1'b0);
      add(1'b1, 1'b0, 32'h0,   1'b1, 11'h002, 1'b1, 32'h4,   32'hA000_0001, 1'b0);
      add(1'b0, 1'b0, 32'h0,   1'b1, 11'h003, 1'b1, 32'h8,   32'hA000_0002, 1'b0);
      add(1'b0, 1'b0, 32'h0,   1'b0, 11'h000, 1'b1, 32'h8,   32'hA000_0002, 1'b0);
      add(1'b0, 1'b0, 32'h0,   1'b0, 11'h000, 1'b1, 32'h8,   32'hA000_0002, 1'b0);
      add(1'b1, 1'b0, 32'h0,   1'b0, 11'h000, 1'b1, 32'h8,   32'hA000_0002, 1'b0);
      add(1'b1, 1'b0, 32'h0,   1'b1, 11'h004, 1'b1, 32'hC,   32'hA000_0003, 1'b0);
      add(1'b1, 1'b0, 32'h0,   1'b1, 11'h005, 1'b1, 32'h10,  32'hA000_0004, 1'b0);
      add(1'b0, 1'b0, 32'h0,   1'b1, 11'h006, 1'b1, 32'h14,  32'hA000_0005, 1'b0);
      add(1'b0, 1'b1, 32'h100, 1'b1, 11'h040, 1'b0, 32'h0,   32'h0,         1'b0);
      add(1'b1, 1'b0, 32'h0,   1'b1, 11'h041, 1'b1, 32'h100, 32'hA000_0040, 1'b0);
      add(1'b1, 1'b1, 32'h102, 1'b1, 11'h040, 1'b0, 32'h0,   32'h0,         1'b0);
      add(1'b1, 1'b0, 32'h0,   1'b1, 11'h041, 1'b1, 32'h102, 32'hA000_0040, 1'b1);
      add(1'b1, 1'b0, 32'h0,   1'b1, 11'h042, 1'b1, 32'h106, 32'hA000_0041, 1'b1);

      repeat (3) @(posedge clk);
      #1;
      check("reset_ce",    {31'd0, imem_ce},  32'd0);
      check("reset_valid", {31'd0, if_valid}, 32'd0);
      check("reset_pc",    if_pc,             32'd0);
      check("reset_instr", if_instr,          32'd0);
      check("reset_fault", {31'd0, if_fault}, 32'd0);
      check("oce",         {31'd0, imem_oce}, 32'd1);
      reset = 1'b0;

      foreach (vecs[i]) begin
         drive(vecs[i].ready, vecs[i].rv, vecs[i].rpc);
         check($sformatf("v%0d_ce", i), {31'd0, imem_ce}, {31'd0, vecs[i].ce});
         if (vecs[i].ce) check($sformatf("v%0d_ad", i), {21'd0, imem_ad}, {21'd0, vecs[i].ad});
         check($sformatf("v%0d_valid", i), {31'd0, if_valid}, {31'd0, vecs[i].valid});
         if (vecs[i].valid) begin
            check($sformatf("v%0d_pc", i), if_pc, vecs[i].pc);
            check($sformatf("v%0d_instr", i), if_instr, vecs[i].instr);
            check($sformatf("v%0d_fault", i), {31'd0, if_fault}, {31'd0, vecs[i].fault});
         end
         tick();
      end

      // Sequential fetch across the end of imem: word 2047 is followed by word 0.
      drive(1'b1, 1'b1, 32'h1FF8);
      check("wrap_redir_ad", {21'd0, imem_ad}, 32'h7FE);
      tick();
      drive(1'b1, 1'b0, 32'h0);
      expect_word("wrap_1ff8", 32'h1FF8, 1'b0);
      tick();
      drive(1'b1, 1'b0, 32'h0);
      expect_word("wrap_1ffc", 32'h1FFC, 1'b0);
      check("wrap_ad0", {21'd0, imem_ad}, 32'h0);
      check("wrap_ce", {31'd0, imem_ce}, 32'd1);
      tick();
      drive(1'b1, 1'b0, 32'h0);
      expect_word("wrap_2000", 32'h2000, 1'b1);
      tick();

      // Stall until both skid and response are occupied, then reset asynchronously.
      drive(1'b0, 1'b0, 32'h0);
      tick();
      drive(1'b0, 1'b0, 32'h0);
      check("pre_rst_valid", {31'd0, if_valid}, 32'd1);
      check("pre_rst_ce", {31'd0, imem_ce}, 32'd0);
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      check("async_rst_ce",    {31'd0, imem_ce},  32'd0);
      check("async_rst_valid", {31'd0, if_valid}, 32'd0);
      check("async_rst_pc",    if_pc,             32'd0);
      check("async_rst_instr", if_instr,          32'd0);
      check("async_rst_fault", {31'd0, if_fault}, 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b0;
      drive(1'b1, 1'b0, 32'h0);
      check("restart_ce", {31'd0, imem_ce}, 32'd1);
      check("restart_ad", {21'd0, imem_ad}, 32'd0);
      check("restart_valid0", {31'd0, if_valid}, 32'd0);
      tick();
      drive(1'b1, 1'b0, 32'h0);
      expect_word("restart", 32'h0, 1'b0);
      tick();

      // Random phase: the model is the delivered PC stream, sequential from the last redirect.
      exp_next = 32'h4;
      hold     = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         logic        r;
         logic        rv;
         logic [31:0] rpc;
         r  = ($urandom % 10) < 7;
         rv = ($urandom % 16) == 0;
         case ($urandom % 4)
            0:       rpc = {19'd0, 11'($urandom_range(0, 2047)), 2'b00};
            1:       rpc = {19'd0, 13'($urandom)};
            2:       rpc = 32'h1FF0 + {28'd0, 4'($urandom)};
            default: rpc = $urandom;
         endcase
         drive(r, rv, rpc);
         check("rnd_valid", {31'd0, if_valid}, {31'd0, !rv});
         if (rv) begin
            check("rnd_redir_ce", {31'd0, imem_ce}, 32'd1);
            check("rnd_redir_ad", {21'd0, imem_ad}, {21'd0, rpc[12:2]});
         end
         if (hold && !rv) begin
            check("rnd_hold_pc", if_pc, hold_pc);
            check("rnd_hold_instr", if_instr, hold_instr);
            check("rnd_hold_fault", {31'd0, if_fault}, {31'd0, hold_fault});
         end
         if (if_valid && if_ready) begin
            check("rnd_pc", if_pc, exp_next);
            check("rnd_instr", if_instr, ref_word(exp_next));
            check("rnd_fault", {31'd0, if_fault}, {31'd0, ref_fault(exp_next)});
            exp_next = exp_next + 32'd4;
         end
         hold       = if_valid && !if_ready;
         hold_pc    = if_pc;
         hold_instr = if_instr;
         hold_fault = if_fault;
         if (rv) exp_next = rpc;
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/imem_fetch.md
Name: imem_fetch

Overview:
- Instruction fetch stage sitting directly upstream of the 2048x32 single-port BSRAM instruction memory.
- Owns the program counter and drives the memory address, chip enable and output enable.
- Absorbs the memory's 1-cycle synchronous read latency.
- Presents fetched instructions to decode over a valid/ready handshake, accepts branch/jump redirects from execute, and breaks the decode-stall path with a 1-entry skid buffer.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; first fetch address.
- IMEM_AW, 11, imem word-address width (2048 words).

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_ad  out  IMEM_AW  word address to imem, = fetch pc[IMEM_AW+1:2].
- imem_ce  out  1  imem read enable; one read issued per cycle it is high.
- imem_oce  out  1  imem output enable; constant 1 (bypass read mode).
- imem_dout  in  32  imem read data, valid the cycle after imem_ce; held while imem_ce=0.
- redirect_valid  in  1  single-cycle pulse: restart fetch at redirect_pc.
- redirect_pc  in  32  redirect target byte address.
- if_valid  out  1  instruction available to decode.
- if_ready  in  1  decode accepts; transfer when if_valid & if_ready.
- if_pc  out  32  byte PC of if_instr.
- if_instr  out  32  instruction word.
- if_fault  out  1  if_pc misaligned (pc[1:0]!=0) or beyond imem (pc[31:IMEM_AW+2]!=0).

Behaviour:
- Reset (async, active-high) forces:
  - pc=RESET_PC; rsp_valid=0; sb_valid=0.
  - imem_ce=0, if_valid=0, if_pc=0, if_instr=0, if_fault=0.
  - Reset asserted mid-operation discards all in-flight and buffered words.
- State:
  - pc: next address to issue.
  - rsp_valid / rsp_pc: a read issued last cycle, data on imem_dout.
  - sb_valid / sb_pc / sb_instr: skid buffer.
- Issue:
  - imem_ce = !reset & (redirect_valid | !sb_valid).
  - Must be a function of registered state and redirect_valid only, never of if_ready.
  - imem_ad = redirect_valid ? redirect_pc[IMEM_AW+1:2] : pc[IMEM_AW+1:2].
  - On issue: rsp_pc <= issued address, rsp_valid <= 1, pc <= issued address + 4.
  - pc addition is 32-bit wrap-around; imem_ad truncates, so word 2047 is followed by word 0.
- Output mux:
  - If sb_valid, present sb_pc/sb_instr; else present rsp_pc/imem_dout.
  - if_valid = (sb_valid | rsp_valid) & !redirect_valid.
- Skid capture:
  - rsp_valid & !sb_valid & !if_ready: copy rsp into skid buffer (sb_valid <= 1). The same cycle still issues the next read.
  - sb_valid: no issue, so imem_dout holds the pending rsp. On sb transfer, sb_valid <= 0 and rsp becomes visible next cycle.
  - rsp_valid & !sb_valid & if_ready: rsp consumed directly.
  - Net effect: no word is ever lost or duplicated.
- Steady-state throughput: 1 instruction/cycle with if_ready held high.
- Redirect:
  - Has priority over everything: clears sb_valid; issues at redirect_pc in the same cycle.
  - Any response from before the redirect is dropped.
  - if_valid is masked low that cycle.
  - Redirect target delivered with if_valid=1 exactly 1 cycle later.
  - Back-to-back redirects: the last one wins.
- Fault:
  - Misaligned or out-of-range PCs still fetch the truncated address; the word is delivered with if_fault=1.
  - The PC continues +4 from the unaligned value.
- if_pc/if_instr/if_fault are don't-care when if_valid=0. They must be stable while if_valid=1 & if_ready=0.

Test Plan:
- Reset release, imem word n preloaded = 32'hA000_0000+n, if_ready=1 → cycle 0 imem_ce=1, ad=0; cycle 1 if_valid, pc 0x0 instr A0000000; one word per cycle, pcs 0x0, 0x4, 0x8...
- if_ready low for 3 cycles after pc 0x8 presented → 0x8 held stable; exactly one extra read (0xC) issued, then imem_ce=0; on release 0x8, 0xC, 0x10 delivered in order, no gaps or duplicates.
- redirect_valid with redirect_pc=0x100 while skid buffer full → if_valid=0 that cycle; next cycle pc 0x100 instr A0000040; buffered words never delivered.
- Sequential fetch crossing pc 0x1FFC → 0x2000 → ad wraps 2047 → 0; pc 0x2000 delivered with instr A0000000 and if_fault=1.
- redirect_pc=0x102 → if_pc 0x102, ad=0x40, if_fault=1; following pc 0x106.
- Reset asserted while if_ready=0 with sb and rsp valid → outputs clear immediately (async); after release, fetch restarts at RESET_PC.
